pipe_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage pipeline. It generates per-stage stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers, plus EX-stage operand forwarding selects. A small FSM sequences three hazards: load-use bubbles, multi-cycle branch flush, and data-memory wait freezes. All stage registers in the pipeline take their stall/flush controls from this block.

---
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the central hazard controller.
// The pipeline side uses the master modport, the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1addr;
    logic [4:0]       id_rs2addr;
    logic [4:0]       id_ex_rs1addr;
    logic [4:0]       id_ex_rs2addr;
    logic [4:0]       id_ex_rdaddr;
    logic             id_ex_memread;
    logic             id_ex_regwrite;
    logic [4:0]       ex_mem_rdaddr;
    logic             ex_mem_regwrite;
    logic [4:0]       mem_wb_rdaddr;
    logic             mem_wb_regwrite;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1addr, id_rs2addr, id_ex_rs1addr, id_ex_rs2addr, id_ex_rdaddr,
               id_ex_memread, id_ex_regwrite, ex_mem_rdaddr, ex_mem_regwrite,
               mem_wb_rdaddr, mem_wb_regwrite, ex_branch_taken, dmem_req, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
               fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1addr, id_rs2addr, id_ex_rs1addr, id_ex_rs2addr, id_ex_rdaddr,
               id_ex_memread, id_ex_regwrite, ex_mem_rdaddr, ex_mem_regwrite,
               mem_wb_rdaddr, mem_wb_regwrite, ex_branch_taken, dmem_req, dmem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
               fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: stall/flush sequencing for load-use, branch and dmem wait, plus EX forwarding.
// Optional saturating performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    localparam logic [3:0] BR_RELOAD = 4'(BR_PENALTY - 1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] fcnt_r;
    logic [3:0] next_fcnt_s;
    logic       memwait_s;
    logic       loaduse_s;
    logic       stall_all_s;
    logic       br_flush_s;
    logic       lu_bubble_s;
    logic       pc_stall_s;
    logic       if_id_flush_s;

    // Select the newest producer of src; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign memwait_s = hz.dmem_req & ~hz.dmem_ready;
    assign loaduse_s = hz.id_ex_memread & hz.id_ex_regwrite & (hz.id_ex_rdaddr != 5'd0) &
                       ((hz.id_ex_rdaddr == hz.id_rs1addr) | (hz.id_ex_rdaddr == hz.id_rs2addr));

    // State and flush-count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_RUN;
            fcnt_r  <= 4'd0;
        end else begin
            state_r <= next_state_s;
            fcnt_r  <= next_fcnt_s;
        end
    end

    // Next-state and flush-count logic.
    always_comb begin
        next_state_s = ST_RUN;
        next_fcnt_s  = 4'd0;
        case (state_r)
            ST_FLUSH: begin
                if (memwait_s) begin
                    next_state_s = ST_FLUSH;
                    next_fcnt_s  = fcnt_r;
                end else begin
                    // A new taken branch restarts the penalty instead of adding to it.
                    if (hz.ex_branch_taken) begin
                        next_fcnt_s = BR_RELOAD;
                    end else begin
                        next_fcnt_s = fcnt_r - 4'd1;
                    end
                    if (next_fcnt_s != 4'd0) begin
                        next_state_s = ST_FLUSH;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
            end
            ST_RUN, ST_LD_STALL, ST_MEM_WAIT: begin
                if (memwait_s) begin
                    next_state_s = ST_MEM_WAIT;
                end else if (hz.ex_branch_taken) begin
                    if (BR_RELOAD != 4'd0) begin
                        next_state_s = ST_FLUSH;
                        next_fcnt_s  = BR_RELOAD;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end else if (loaduse_s && (state_r != ST_LD_STALL)) begin
                    next_state_s = ST_LD_STALL;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                next_state_s = ST_RUN;
                next_fcnt_s  = 4'd0;
            end
        endcase
    end

    // Hazard action decode: freeze everything, branch flush, or a single load-use bubble.
    always_comb begin
        stall_all_s = 1'b0;
        br_flush_s  = 1'b0;
        lu_bubble_s = 1'b0;
        case (state_r)
            ST_FLUSH: begin
                if (memwait_s) begin
                    stall_all_s = 1'b1;
                end else begin
                    br_flush_s = 1'b1;
                end
            end
            ST_RUN, ST_LD_STALL, ST_MEM_WAIT: begin
                if (memwait_s) begin
                    stall_all_s = 1'b1;
                end else if (hz.ex_branch_taken) begin
                    br_flush_s = 1'b1;
                end else if (loaduse_s && (state_r != ST_LD_STALL)) begin
                    lu_bubble_s = 1'b1;
                end else begin
                    stall_all_s = 1'b0;
                end
            end
            default: begin
                stall_all_s = 1'b0;
            end
        endcase
    end

    assign pc_stall_s      = rst & (stall_all_s | lu_bubble_s);
    assign if_id_flush_s   = rst & br_flush_s;
    assign hz.pc_stall     = pc_stall_s;
    assign hz.if_id_stall  = rst & (stall_all_s | lu_bubble_s);
    assign hz.id_ex_stall  = rst & stall_all_s;
    assign hz.ex_mem_stall = rst & stall_all_s;
    assign hz.if_id_flush  = if_id_flush_s;
    assign hz.id_ex_flush  = rst & (br_flush_s | lu_bubble_s);
    assign hz.state        = state_r;

    assign hz.fwd_a = rst ? fwd_sel(hz.id_ex_rs1addr, hz.ex_mem_rdaddr, hz.ex_mem_regwrite,
                                    hz.mem_wb_rdaddr, hz.mem_wb_regwrite) : 2'b00;
    assign hz.fwd_b = rst ? fwd_sel(hz.id_ex_rs2addr, hz.ex_mem_rdaddr, hz.ex_mem_regwrite,
                                    hz.mem_wb_rdaddr, hz.mem_wb_regwrite) : 2'b00;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating stall/flush cycle counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (pc_stall_s && (stall_cnt_r != '1)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (if_id_flush_s && (flush_cnt_r != '1)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_r;
    assign hz.flush_cnt = flush_cnt_r;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a reference model.
// Counter expectations follow whether PIPE_HAZARD_PERF_EN is defined for the build.
module tb_pipe_hazard_ctrl;

    localparam int P  = 3;
    localparam int CW = 4;
`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int SAT = PERF ? 15 : 0;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [5:0] ctl;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hif();
    pipe_hazard_ctrl #(.BR_PENALTY(P), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hif));

    always #5 clk = ~clk;

    assign ctl = {hif.pc_stall, hif.if_id_stall, hif.id_ex_stall, hif.ex_mem_stall,
                  hif.if_id_flush, hif.id_ex_flush};

    task automatic clear_inputs();
        hif.id_rs1addr = 5'd0; hif.id_rs2addr = 5'd0;
        hif.id_ex_rs1addr = 5'd0; hif.id_ex_rs2addr = 5'd0; hif.id_ex_rdaddr = 5'd0;
        hif.id_ex_memread = 1'b0; hif.id_ex_regwrite = 1'b0;
        hif.ex_mem_rdaddr = 5'd0; hif.ex_mem_regwrite = 1'b0;
        hif.mem_wb_rdaddr = 5'd0; hif.mem_wb_regwrite = 1'b0;
        hif.ex_branch_taken = 1'b0; hif.dmem_req = 1'b0; hif.dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        hif.dmem_req = 1'b1; hif.ex_branch_taken = 1'b1;
        hif.id_ex_memread = 1'b1; hif.id_ex_regwrite = 1'b1; hif.id_ex_rdaddr = 5'd5; hif.id_rs1addr = 5'd5;
        hif.ex_mem_regwrite = 1'b1; hif.ex_mem_rdaddr = 5'd3; hif.id_ex_rs1addr = 5'd3; hif.id_ex_rs2addr = 5'd3;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); end
        checks++; if ({hif.fwd_a, hif.fwd_b} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", {hif.fwd_a, hif.fwd_b}); end
        next_cycle();
        @(negedge clk);
        checks++; if (hif.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", hif.state); end
        checks++; if ({hif.stall_cnt, hif.flush_cnt} !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h expected 00", {hif.stall_cnt, hif.flush_cnt}); end
        rst = 1'b1;
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        hif.id_ex_memread = 1'b1; hif.id_ex_regwrite = 1'b1; hif.id_ex_rdaddr = 5'd5; hif.id_rs1addr = 5'd5;
        @(negedge clk);
        checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL lu_bubble: got %b expected %b", ctl, 6'b110001); end
        next_cycle();
        @(negedge clk);
        checks++; if (hif.state !== 2'd1) begin errors++; $display("FAIL lu_state: got %0d expected 1", hif.state); end
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_masked: got %b expected 000000", ctl); end
        next_cycle();
        clear_inputs();
        hif.id_ex_rs1addr = 5'd5; hif.mem_wb_rdaddr = 5'd5; hif.mem_wb_regwrite = 1'b1;
        @(negedge clk);
        checks++; if (hif.state !== 2'd0) begin errors++; $display("FAIL lu_back_run: got %0d expected 0", hif.state); end
        checks++; if ({hif.fwd_a, hif.fwd_b} !== 4'b0100) begin errors++; $display("FAIL lu_fwd: got %b expected 0100", {hif.fwd_a, hif.fwd_b}); end
        next_cycle();
        clear_inputs();
        hif.id_ex_memread = 1'b1; hif.id_ex_regwrite = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_x0: got %b expected 000000", ctl); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch();
        int nflush = 0;
        do_reset();
        hif.ex_branch_taken = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nflush += int'(hif.if_id_flush);
            checks++;
            if (ctl !== ((i < P) ? 6'b000011 : 6'b000000)) begin
                errors++; $display("FAIL br_ctl[%0d]: got %b expected %b", i, ctl, (i < P) ? 6'b000011 : 6'b000000);
            end
            checks++;
            if (hif.state !== ((i >= 1 && i < P) ? 2'd3 : 2'd0)) begin
                errors++; $display("FAIL br_state[%0d]: got %0d expected %0d", i, hif.state, (i >= 1 && i < P) ? 3 : 0);
            end
            next_cycle();
            hif.ex_branch_taken = 1'b0;
        end
        checks++; if (nflush != P) begin errors++; $display("FAIL br_total: got %0d expected %0d", nflush, P); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        hif.dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL mw_ctl[%0d]: got %b expected 111100", i, ctl); end
            checks++; if (hif.state !== ((i == 0) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL mw_state[%0d]: got %0d", i, hif.state); end
            next_cycle();
        end
        hif.dmem_ready = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL mw_release: got %b expected 000000", ctl); end
        checks++; if (hif.state !== 2'd2) begin errors++; $display("FAIL mw_release_state: got %0d expected 2", hif.state); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (hif.state !== 2'd0) begin errors++; $display("FAIL mw_done_state: got %0d expected 0", hif.state); end
        checks++; if (int'(hif.stall_cnt) != (PERF ? 4 : 0)) begin errors++; $display("FAIL mw_stall_cnt: got %0d expected %0d", hif.stall_cnt, PERF ? 4 : 0); end
    endtask

    task automatic test_flush_memwait();
        int nflush;
        do_reset();
        hif.ex_branch_taken = 1'b1;
        @(negedge clk);
        nflush = int'(hif.if_id_flush);
        next_cycle();
        hif.ex_branch_taken = 1'b0; hif.dmem_req = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL fm_hold: got %b expected 111100", ctl); end
        checks++; if (hif.state !== 2'd3) begin errors++; $display("FAIL fm_hold_state: got %0d expected 3", hif.state); end
        next_cycle();
        hif.dmem_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nflush += int'(hif.if_id_flush);
            checks++; if (hif.state !== ((i < 2) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL fm_state[%0d]: got %0d", i, hif.state); end
            next_cycle();
        end
        checks++; if (nflush != P) begin errors++; $display("FAIL fm_total: got %0d expected %0d", nflush, P); end
        checks++; if (int'(hif.flush_cnt) != (PERF ? P : 0)) begin errors++; $display("FAIL fm_flush_cnt: got %0d expected %0d", hif.flush_cnt, PERF ? P : 0); end
    endtask

    task automatic test_forwarding();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin hif.ex_mem_rdaddr = 5'd7; hif.mem_wb_rdaddr = 5'd7; hif.ex_mem_regwrite = 1'b1; hif.mem_wb_regwrite = 1'b1;
                         hif.id_ex_rs1addr = 5'd7; hif.id_ex_rs2addr = 5'd7; exp = 4'b1010; end
                1: begin hif.ex_mem_regwrite = 1'b1; hif.mem_wb_regwrite = 1'b1; exp = 4'b0000; end
                2: begin hif.ex_mem_rdaddr = 5'd7; hif.mem_wb_rdaddr = 5'd7; hif.mem_wb_regwrite = 1'b1;
                         hif.id_ex_rs1addr = 5'd7; hif.id_ex_rs2addr = 5'd3; exp = 4'b0100; end
                default: begin hif.ex_mem_rdaddr = 5'd4; hif.mem_wb_rdaddr = 5'd6; hif.ex_mem_regwrite = 1'b1; hif.mem_wb_regwrite = 1'b1;
                         hif.id_ex_rs1addr = 5'd6; hif.id_ex_rs2addr = 5'd4; exp = 4'b0110; end
            endcase
            @(negedge clk);
            checks++; if ({hif.fwd_a, hif.fwd_b} !== exp) begin errors++; $display("FAIL fwd_case%0d: got %b expected %b", i, {hif.fwd_a, hif.fwd_b}, exp); end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_counter_sat();
        do_reset();
        hif.dmem_req = 1'b1;
        repeat (20) next_cycle();
        @(negedge clk);
        checks++; if (int'(hif.stall_cnt) != SAT) begin errors++; $display("FAIL sat_stall: got %0d expected %0d", hif.stall_cnt, SAT); end
        checks++; if (hif.state !== 2'd2) begin errors++; $display("FAIL sat_state: got %0d expected 2", hif.state); end
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (hif.state !== 2'd0) begin errors++; $display("FAIL midmw_rst_state: got %0d expected 0", hif.state); end
        checks++; if ({hif.stall_cnt, hif.flush_cnt} !== 8'h00) begin errors++; $display("FAIL midmw_rst_cnt: got %h expected 00", {hif.stall_cnt, hif.flush_cnt}); end
        rst = 1'b1;
        clear_inputs();
        hif.ex_branch_taken = 1'b1;
        repeat (20) next_cycle();
        @(negedge clk);
        checks++; if (int'(hif.flush_cnt) != SAT) begin errors++; $display("FAIL sat_flush: got %0d expected %0d", hif.flush_cnt, SAT); end
        next_cycle();
        clear_inputs();
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (hif.ex_mem_regwrite && hif.ex_mem_rdaddr != 5'd0 && hif.ex_mem_rdaddr == src) return 2'b10;
        if (hif.mem_wb_regwrite && hif.mem_wb_rdaddr != 5'd0 && hif.mem_wb_rdaddr == src) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: mode is the architectural state number, owed = flush cycles still owed after this one.
    task automatic test_random();
        int mode = 0, owed = 0, scnt = 0, fcnt = 0;
        int n_mode, n_owed;
        bit mw, lu, freeze, flush, bubble;
        logic [5:0] exp_ctl;
        logic [3:0] exp_fwd;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            hif.id_rs1addr = 5'($urandom_range(0, 3)); hif.id_rs2addr = 5'($urandom_range(0, 3));
            hif.id_ex_rs1addr = 5'($urandom_range(0, 3)); hif.id_ex_rs2addr = 5'($urandom_range(0, 3));
            hif.id_ex_rdaddr = 5'($urandom_range(0, 3));
            hif.id_ex_memread = 1'($urandom_range(0, 1)); hif.id_ex_regwrite = 1'($urandom_range(0, 3) != 0);
            hif.ex_mem_rdaddr = 5'($urandom_range(0, 3)); hif.ex_mem_regwrite = 1'($urandom_range(0, 1));
            hif.mem_wb_rdaddr = 5'($urandom_range(0, 3)); hif.mem_wb_regwrite = 1'($urandom_range(0, 1));
            hif.ex_branch_taken = 1'($urandom_range(0, 99) < 15);
            hif.dmem_req = 1'($urandom_range(0, 99) < 35); hif.dmem_ready = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;

            mw = hif.dmem_req && !hif.dmem_ready;
            lu = hif.id_ex_memread && hif.id_ex_regwrite && hif.id_ex_rdaddr != 5'd0 &&
                 (hif.id_ex_rdaddr == hif.id_rs1addr || hif.id_ex_rdaddr == hif.id_rs2addr);
            freeze = 1'b0; flush = 1'b0; bubble = 1'b0; n_mode = 0; n_owed = 0;
            if (mode == 3 && mw) begin
                freeze = 1'b1; n_mode = 3; n_owed = owed;
            end else if (mode == 3) begin
                flush = 1'b1;
                n_owed = hif.ex_branch_taken ? P - 1 : owed - 1;
                n_mode = (n_owed > 0) ? 3 : 0;
            end else if (mw) begin
                freeze = 1'b1; n_mode = 2;
            end else if (hif.ex_branch_taken) begin
                flush = 1'b1; n_owed = P - 1; n_mode = (n_owed > 0) ? 3 : 0;
            end else if (lu && mode != 1) begin
                bubble = 1'b1; n_mode = 1;
            end
            exp_ctl = {freeze | bubble, freeze | bubble, freeze, freeze, flush, flush | bubble};
            exp_fwd = {ref_fwd(hif.id_ex_rs1addr), ref_fwd(hif.id_ex_rs2addr)};
            if (!rst) begin
                exp_ctl = 6'b000000; exp_fwd = 4'b0000; n_mode = 0; n_owed = 0;
            end

            @(negedge clk);
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL rnd_ctl@%0d: got %b expected %b", c, ctl, exp_ctl); end
            checks++; if ({hif.fwd_a, hif.fwd_b} !== exp_fwd) begin errors++; $display("FAIL rnd_fwd@%0d: got %b expected %b", c, {hif.fwd_a, hif.fwd_b}, exp_fwd); end
            checks++; if (int'(hif.state) != mode) begin errors++; $display("FAIL rnd_state@%0d: got %0d expected %0d", c, hif.state, mode); end
            checks++; if (int'(hif.stall_cnt) != scnt || int'(hif.flush_cnt) != fcnt) begin
                errors++; $display("FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", c, hif.stall_cnt, hif.flush_cnt, scnt, fcnt);
            end

            if (!rst) begin
                scnt = 0; fcnt = 0;
            end else if (PERF) begin
                if (exp_ctl[5] && scnt < 15) scnt++;
                if (exp_ctl[1] && fcnt < 15) fcnt++;
            end
            mode = n_mode; owed = n_owed;
            next_cycle();
        end
        rst = 1'b1;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_flush_memwait();
        test_forwarding();
        test_counter_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
